// File: rtl/button_conditioner.sv
// Pushbutton front-end: 2-flop sync, per-button debounce,
// typematic step pulses for U/D/L/R and one-shot paint pulse.
module button_conditioner #(
  parameter int NUM_BTN             = 5,
  parameter int DEBOUNCE_CYCLES     = 1000000,
  parameter int REPEAT_DELAY_CYCLES = 40000000,
  parameter int REPEAT_RATE_CYCLES  = 5000000,
  parameter int CNT_W               = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               any_active
);

  localparam logic [CNT_W-1:0] DB_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_MAX =
    CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_MAX =
    CNT_W'(REPEAT_RATE_CYCLES - 1);
  localparam longint CNT_LIM = longint'(1) << CNT_W;

  if (NUM_BTN != 5 ||
      DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY_CYCLES < 1 ||
      REPEAT_RATE_CYCLES < 1 ||
      longint'(DEBOUNCE_CYCLES) > CNT_LIM ||
      longint'(REPEAT_DELAY_CYCLES) > CNT_LIM ||
      longint'(REPEAT_RATE_CYCLES) > CNT_LIM) begin : g_bad_param
    $error("button_conditioner: illegal parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] s2;
  logic [NUM_BTN-1:0] db;
  logic [CNT_W-1:0]   db_cnt [NUM_BTN];
  logic               paint_pulse;
  logic [3:0]         dir_pulse;
  rep_state_t         rep_state [4];
  logic [CNT_W-1:0]   rep_cnt [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < NUM_BTN; i++)
        db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (s2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db[i]     <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // db is the next btn_level; pulses register alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_level   <= '0;
      any_active  <= 1'b0;
      paint_pulse <= 1'b0;
    end else begin
      btn_level   <= db;
      any_active  <= |btn_level;
      paint_pulse <= db[4] & ~btn_level[4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_pulse <= '0;
      for (int i = 0; i < 4; i++) begin
        rep_state[i] <= IDLE;
        rep_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        dir_pulse[i] <= 1'b0;
        if (!db[i]) begin
          rep_state[i] <= IDLE;
          rep_cnt[i]   <= '0;
        end else begin
          unique case (rep_state[i])
            IDLE: begin
              dir_pulse[i] <= 1'b1;
              rep_cnt[i]   <= '0;
              rep_state[i] <= DELAY;
            end
            DELAY: begin
              if (rep_cnt[i] == DLY_MAX) begin
                dir_pulse[i] <= 1'b1;
                rep_cnt[i]   <= '0;
                rep_state[i] <= REPEAT;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + CNT_W'(1);
              end
            end
            REPEAT: begin
              if (rep_cnt[i] == RATE_MAX) begin
                dir_pulse[i] <= 1'b1;
                rep_cnt[i]   <= '0;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + CNT_W'(1);
              end
            end
            default: begin
              rep_state[i] <= IDLE;
              rep_cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // opposing directions held together cancel each other
  assign btn_pulse = {
    paint_pulse,
    dir_pulse[3:2] & ~{2{&btn_level[3:2]}},
    dir_pulse[1:0] & ~{2{&btn_level[1:0]}}
  };

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short
// debounce/repeat periods (4 / 10 / 3).
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;
  logic       any_active;

  int checks   = 0;
  int failures = 0;

  button_conditioner #(
    .NUM_BTN(5),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_RATE_CYCLES(3),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .any_active(any_active)
  );

  always #5 clk = ~clk;

  // typematic slots relative to the accepting edge
  function automatic bit rep_slot(int o);
    return o == 0 || (o >= 10 && (o - 10) % 3 == 0);
  endfunction

  task automatic test_reset();
    reset   = 1'b1;
    btn_raw = '0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({btn_level, btn_pulse, any_active} !== 11'b0) begin
        failures++;
        $display("FAIL reset: level=%b pulse=%b act=%b req 0",
                 btn_level, btn_pulse, any_active);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    logic [4:0] el, ep;
    logic       ea;
    for (int j = 1; j <= 20; j++) begin
      btn_raw    = '0;
      btn_raw[0] = (j <= 9);
      @(negedge clk);
      el = '0; ep = '0;
      el[0] = (j >= 7 && j < 16);
      ep[0] = (j == 7);
      ea    = (j >= 8 && j < 17);
      checks++;
      if (btn_level !== el) begin
        failures++;
        $display("FAIL latency_level j=%0d: got %b req %b",
                 j, btn_level, el);
      end
      checks++;
      if (btn_pulse !== ep) begin
        failures++;
        $display("FAIL latency_pulse j=%0d: got %b req %b",
                 j, btn_pulse, ep);
      end
      checks++;
      if (any_active !== ea) begin
        failures++;
        $display("FAIL latency_active j=%0d: got %b req %b",
                 j, any_active, ea);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] el, ep;
    int np = 0;
    for (int j = 1; j <= 40; j++) begin
      btn_raw    = '0;
      btn_raw[2] = (j <= 3) || (j == 5) || (j == 6) ||
                   (j >= 15 && j <= 24);
      @(negedge clk);
      el = '0; ep = '0;
      el[2] = (j >= 21 && j < 31);
      ep[2] = (j == 21);
      if (btn_pulse[2]) np++;
      checks++;
      if (btn_level !== el || btn_pulse !== ep) begin
        failures++;
        $display("FAIL bounce j=%0d: lvl=%b pls=%b req %b %b",
                 j, btn_level, btn_pulse, el, ep);
      end
    end
    checks++;
    if (np !== 1) begin
      failures++;
      $display("FAIL bounce_count: got %0d req 1", np);
    end
  endtask

  task automatic test_repeat();
    logic [4:0] el, ep;
    int np = 0;
    for (int j = 1; j <= 45; j++) begin
      btn_raw    = '0;
      btn_raw[3] = (j <= 30);
      @(negedge clk);
      el = '0; ep = '0;
      el[3] = (j >= 7 && j < 37);
      ep[3] = el[3] && rep_slot(j - 7);
      if (btn_pulse[3]) np++;
      checks++;
      if (btn_level !== el || btn_pulse !== ep) begin
        failures++;
        $display("FAIL repeat j=%0d: lvl=%b pls=%b req %b %b",
                 j, btn_level, btn_pulse, el, ep);
      end
    end
    checks++;
    if (np !== 8) begin
      failures++;
      $display("FAIL repeat_count: got %0d req 8", np);
    end
  endtask

  task automatic test_paint();
    logic [4:0] el, ep;
    int np = 0;
    for (int j = 1; j <= 85; j++) begin
      btn_raw    = '0;
      btn_raw[4] = (j <= 50) || (j >= 61 && j <= 70);
      @(negedge clk);
      el = '0; ep = '0;
      el[4] = (j >= 7 && j < 57) || (j >= 67 && j < 77);
      ep[4] = (j == 7) || (j == 67);
      if (btn_pulse[4]) np++;
      checks++;
      if (btn_level !== el || btn_pulse !== ep) begin
        failures++;
        $display("FAIL paint j=%0d: lvl=%b pls=%b req %b %b",
                 j, btn_level, btn_pulse, el, ep);
      end
    end
    checks++;
    if (np !== 2) begin
      failures++;
      $display("FAIL paint_count: got %0d req 2", np);
    end
  endtask

  task automatic test_opposing();
    logic [4:0] el, ep;
    bit up, dn;
    for (int j = 1; j <= 70; j++) begin
      btn_raw    = '0;
      btn_raw[0] = (j <= 55);
      btn_raw[3] = (j <= 55);
      btn_raw[1] = (j >= 20 && j <= 39);
      @(negedge clk);
      up = (j >= 7 && j < 62);
      dn = (j >= 26 && j < 46);
      el = {1'b0, up, 1'b0, dn, up};
      ep = '0;
      ep[3] = up && rep_slot(j - 7);
      ep[0] = ep[3] && !dn;
      checks++;
      if (btn_level !== el || btn_pulse !== ep) begin
        failures++;
        $display("FAIL opposing j=%0d: lvl=%b pls=%b req %b %b",
                 j, btn_level, btn_pulse, el, ep);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] el, ep;
    logic       ea;
    bit         lv;
    for (int j = 1; j <= 45; j++) begin
      btn_raw    = 5'b00010;
      reset      = (j == 20 || j == 21);
      @(negedge clk);
      lv = (j >= 7 && j < 20) || (j >= 28);
      el = '0; ep = '0;
      el[1] = lv;
      ep[1] = (j == 7) || (j == 17) ||
              (j >= 28 && rep_slot(j - 28));
      ea = (j >= 8 && j < 20) || (j >= 29);
      checks++;
      if (btn_level !== el || btn_pulse !== ep ||
          any_active !== ea) begin
        failures++;
        $display("FAIL reset_mid j=%0d: l=%b p=%b a=%b req %b %b %b",
                 j, btn_level, btn_pulse, any_active, el, ep, ea);
      end
    end
    reset   = 1'b0;
    btn_raw = '0;
    for (int j = 0; j < 10; j++) @(negedge clk);
    checks++;
    if (btn_level !== 5'b0 || btn_pulse !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_release: l=%b p=%b req 0 0",
               btn_level, btn_pulse);
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = '0;
    test_reset();
    test_latency();
    test_bounce();
    test_repeat();
    test_paint();
    test_opposing();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
